// File: rtl/stream_serializer_pkg.sv
// stream_serializer_pkg: shared state encoding and default widths for the wide-to-narrow stream serializer
package stream_serializer_pkg;
    typedef enum logic {IDLE, SEND} state_t;
    localparam int DEF_INPUT_DATA_WIDTH  = 512;
    localparam int DEF_OUTPUT_DATA_WIDTH = 32;
endpackage

// File: rtl/stream_response_serializer_keep_last_word_finder.sv
// keep_last_word_finder: priority-encodes the highest narrow word with any keep bit set and flags an all-zero keep
module keep_last_word_finder #(
    parameter int WORDS = 16,
    parameter int KW    = 4,
    parameter int IW    = WORDS > 1 ? $clog2(WORDS) : 1
) (
    input  logic [WORDS*KW-1:0] keep,
    output logic [IW-1:0]       last_idx,
    output logic                none
);
    always_comb begin
        last_idx = '0;
        for (int i = 0; i < WORDS; i++)
            if (|keep[i*KW +: KW]) last_idx = IW'(i);
    end
    assign none = ~|keep;
endmodule

// File: rtl/stream_response_serializer.sv
// stream_response_serializer: splits each wide AXI-Stream beat into narrow words 0..L (L = highest word with keep set).
// Define SERIALIZER_BYTE_SWAP_EN to byte-reverse every output word and its keep.
module stream_response_serializer
    import stream_serializer_pkg::*;
#(
    parameter int INPUT_DATA_WIDTH  = DEF_INPUT_DATA_WIDTH,
    parameter int OUTPUT_DATA_WIDTH = DEF_OUTPUT_DATA_WIDTH
) (
    input  logic                           i_clk,
    input  logic                           i_aresetn,
    input  logic                           i_input_TVALID,
    output logic                           o_input_TREADY,
    input  logic [INPUT_DATA_WIDTH-1:0]    i_input_TDATA,
    input  logic [INPUT_DATA_WIDTH/8-1:0]  i_input_TKEEP,
    input  logic                           i_input_TLAST,
    output logic                           o_output_TVALID,
    input  logic                           i_output_TREADY,
    output logic [OUTPUT_DATA_WIDTH-1:0]   o_output_TDATA,
    output logic [OUTPUT_DATA_WIDTH/8-1:0] o_output_TKEEP,
    output logic                           o_output_TLAST
);
    localparam int R  = INPUT_DATA_WIDTH / OUTPUT_DATA_WIDTH;
    localparam int KW = OUTPUT_DATA_WIDTH / 8;
    localparam int CW = R > 1 ? $clog2(R) : 1;

    state_t                          state, next_state;
    logic                            ready_en;
    logic [INPUT_DATA_WIDTH-1:0]     data_q;
    logic [INPUT_DATA_WIDTH/8-1:0]   keep_q;
    logic                            last_q;
    logic [CW-1:0]                   last_idx, new_idx, cnt;
    logic                            new_none, in_fire, out_fire, at_last;
    logic [OUTPUT_DATA_WIDTH-1:0]    word;
    logic [KW-1:0]                   word_keep;

    keep_last_word_finder #(.WORDS(R), .KW(KW), .IW(CW)) finder (
        .keep(i_input_TKEEP),
        .last_idx(new_idx),
        .none(new_none)
    );

    assign in_fire   = i_input_TVALID & o_input_TREADY;
    assign out_fire  = o_output_TVALID & i_output_TREADY;
    assign at_last   = cnt == last_idx;
    assign word      = data_q[cnt*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH];
    assign word_keep = keep_q[cnt*KW +: KW];

    always_ff @(posedge i_clk or negedge i_aresetn)
        if (!i_aresetn) state <= IDLE;
        else            state <= next_state;

    always_comb
        next_state = in_fire ? (new_none ? IDLE : SEND)
                   : (state == SEND && out_fire && at_last) ? IDLE : state;

    // ready_en holds input ready low until the first edge after reset release
    always_ff @(posedge i_clk or negedge i_aresetn)
        if (!i_aresetn) begin
            ready_en <= 1'b0;
            data_q   <= '0;
            keep_q   <= '0;
            last_q   <= 1'b0;
            last_idx <= '0;
            cnt      <= '0;
        end else begin
            ready_en <= 1'b1;
            if (in_fire) begin
                data_q   <= i_input_TDATA;
                keep_q   <= i_input_TKEEP;
                last_q   <= i_input_TLAST;
                last_idx <= new_idx;
                cnt      <= '0;
            end else if (out_fire && !at_last) begin
                cnt <= cnt + CW'(1);
            end
        end

    always_comb begin
        o_output_TVALID = state == SEND;
        o_input_TREADY  = state == IDLE ? ready_en : i_output_TREADY & at_last;
        o_output_TLAST  = state == SEND && last_q && at_last;
`ifdef SERIALIZER_BYTE_SWAP_EN
        o_output_TDATA  = '0;
        o_output_TKEEP  = '0;
        for (int b = 0; b < KW; b++) begin
            o_output_TDATA[b*8 +: 8] = word[(KW-1-b)*8 +: 8];
            o_output_TKEEP[b]        = word_keep[KW-1-b];
        end
`else
        o_output_TDATA  = word;
        o_output_TKEEP  = word_keep;
`endif
    end
endmodule

// File: tb/tb_stream_response_serializer.sv
// tb_stream_response_serializer: randomized and directed checks against a queue-based model of the serializer
module tb_stream_response_serializer;
    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } word_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic [511:0] in_data = '0;
    logic [63:0]  in_keep = '0;
    logic         o_input_TREADY, o_output_TVALID, o_output_TLAST;
    logic [31:0]  o_output_TDATA;
    logic [3:0]   o_output_TKEEP;

    int    n_tests = 0, n_fail = 0;
    int    mode = 0, cyc = 0, hs_cnt = 0, first_hs = 0, last_hs = 0, send_ticks = 0;
    logic  acc;
    word_t exp_q[$];

    stream_response_serializer dut (
        .i_clk(clk), .i_aresetn(rst_n),
        .i_input_TVALID(in_valid), .o_input_TREADY(o_input_TREADY),
        .i_input_TDATA(in_data), .i_input_TKEEP(in_keep), .i_input_TLAST(in_last),
        .o_output_TVALID(o_output_TVALID), .i_output_TREADY(out_ready),
        .o_output_TDATA(o_output_TDATA), .o_output_TKEEP(o_output_TKEEP), .o_output_TLAST(o_output_TLAST)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] swap_d(input logic [31:0] w);
`ifdef SERIALIZER_BYTE_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic logic [3:0] swap_k(input logic [3:0] k);
`ifdef SERIALIZER_BYTE_SWAP_EN
        return {k[0], k[1], k[2], k[3]};
`else
        return k;
`endif
    endfunction

    // A beat yields words 0..L, L being the highest word with any keep bit; none if keep is all zero
    function automatic void model(input logic [511:0] d, input logic [63:0] k, input logic l);
        int top = -1;
        for (int i = 0; i < 16; i++) if (k[i*4 +: 4] != 4'h0) top = i;
        for (int i = 0; i <= top; i++)
            exp_q.push_back('{swap_d(d[i*32 +: 32]), swap_k(k[i*4 +: 4]), l && i == top});
    endfunction

    task automatic tick();
        word_t w;
        out_ready = mode == 1 ? ~out_ready : mode == 2 ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        check("tvalid", 64'(o_output_TVALID), 64'(exp_q.size() != 0));
        check("in_ready", 64'(o_input_TREADY), 64'(exp_q.size() == 0 || (out_ready && exp_q.size() == 1)));
        if (o_output_TVALID && exp_q.size() != 0) begin
            w = exp_q[0];
            check("tdata", 64'(o_output_TDATA), 64'(w.d));
            check("tkeep", 64'(o_output_TKEEP), 64'(w.k));
            check("tlast", 64'(o_output_TLAST), 64'(w.l));
            if (out_ready) begin
                void'(exp_q.pop_front());
                if (hs_cnt == 0) first_hs = cyc;
                last_hs = cyc;
                hs_cnt++;
            end
        end
        acc = in_valid && o_input_TREADY;
        if (acc) model(in_data, in_keep, in_last);
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input logic [511:0] d, input logic [63:0] k, input logic l);
        in_valid = 1'b1; in_data = d; in_keep = k; in_last = l;
        acc = 1'b0;
        send_ticks = 0;
        while (!acc && send_ticks < 200) begin
            tick();
            send_ticks++;
        end
        if (!acc) check("send_timeout", 64'(0), 64'(1));
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'(0));
        tick();
    endtask

    function automatic logic [511:0] ramp(input int base);
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = 32'(base + i);
        return d;
    endfunction

    initial begin
        logic [511:0] d;
        logic [63:0]  k;
        @(negedge clk);
        check("rst_tvalid", 64'(o_output_TVALID), 64'(0));
        check("rst_tready", 64'(o_input_TREADY), 64'(0));
        check("rst_tdata", 64'(o_output_TDATA), 64'(0));
        check("rst_tkeep", 64'(o_output_TKEEP), 64'(0));
        check("rst_tlast", 64'(o_output_TLAST), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("rel_tready_low", 64'(o_input_TREADY), 64'(0));
        @(negedge clk);

        // full beat, ready held high: 16 consecutive words
        mode = 0; hs_cnt = 0;
        send(ramp(0), '1, 1'b1); drain();
        check("full_count", 64'(hs_cnt), 64'(16));
        check("full_span", 64'(last_hs - first_hs), 64'(15));

        // partial keep
        hs_cnt = 0;
        send(ramp(100), 64'h00F9, 1'b0); drain();
        check("partial_count", 64'(hs_cnt), 64'(2));

        // alternating backpressure
        mode = 1; out_ready = 1'b0; hs_cnt = 0;
        send(ramp(200), '1, 1'b1); drain();
        check("bp_count", 64'(hs_cnt), 64'(16));
        check("bp_span", 64'(last_hs - first_hs), 64'(30));

        // back-to-back beats
        mode = 0; hs_cnt = 0;
        send(ramp(300), '1, 1'b0);
        send(ramp(400), '1, 1'b1); drain();
        check("b2b_count", 64'(hs_cnt), 64'(32));
        check("b2b_span", 64'(last_hs - first_hs), 64'(31));

        // all-zero keep is swallowed in one cycle
        hs_cnt = 0;
        send(ramp(500), '0, 1'b1);
        check("zero_accept_cycles", 64'(send_ticks), 64'(1));
        drain();
        check("zero_count", 64'(hs_cnt), 64'(0));

        // single-word beat with a recognisable byte pattern
        d = '0; d[31:0] = 32'h11223344;
        send(d, 64'hF, 1'b1); drain();

        // reset in the middle of a beat
        hs_cnt = 0;
        send(ramp(600), '1, 1'b1);
        in_valid = 1'b0;
        while (hs_cnt < 6 && cyc < 90000) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_tvalid", 64'(o_output_TVALID), 64'(0));
        check("midrst_tready", 64'(o_input_TREADY), 64'(0));
        check("midrst_tdata", 64'(o_output_TDATA), 64'(0));
        check("midrst_tkeep", 64'(o_output_TKEEP), 64'(0));
        check("midrst_tlast", 64'(o_output_TLAST), 64'(0));
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("midrel_tready_low", 64'(o_input_TREADY), 64'(0));
        @(negedge clk);
        repeat (20) tick();

        // randomized traffic
        mode = 2;
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
            k = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: k = '1;
                1: k = '0;
                2: k = k & ((64'd1 << (4 * $urandom_range(1, 16))) - 64'd1);
                default: ;
            endcase
            send(d, k, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
            end
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
